// File: rtl/dsp19x2_fir_pkg.sv
// rtl/dsp19x2_fir_pkg.sv - shared types and DSP19X2 FEEDBACK codes for the FIR tap sequencer
package dsp19x2_fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  // The DSP holds four coefficient slots per lane, which caps the tap count.
  localparam int TAPS_MAX = 4;
  localparam int S_W      = 9;
  localparam int Z_W      = 19;

  // FEEDBACK code that parks the DSP coefficient select.
  localparam logic [2:0] FB_IDLE = 3'd0;

  // FEEDBACK codes selecting COEFFx_0..COEFFx_3.
  localparam logic [2:0] FB_COEFF [TAPS_MAX] = '{3'd4, 3'd5, 3'd6, 3'd7};

endpackage

// File: rtl/dsp19x2_fir_lane.sv
// rtl/dsp19x2_fir_lane.sv - one FIR lane: sample delay line, tap mux and product accumulator
module dsp19x2_fir_lane
  import dsp19x2_fir_pkg::*;
#(
  parameter int TAPS  = 4,
  parameter int ACC_W = 24
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             shift_i,
  input  logic [S_W-1:0]   sample_i,
  input  logic [1:0]       tap_sel_i,
  input  logic             tap_en_i,
  input  logic             acc_en_i,
  input  logic             zext_i,
  input  logic [Z_W-1:0]   z_i,
  output logic [S_W-1:0]   tap_o,
  output logic [ACC_W-1:0] acc_o
);

  // Slots at or beyond TAPS are never loaded, so they stay zero and never contribute.
  logic [S_W-1:0]   dline_q [TAPS_MAX];
  logic [S_W-1:0]   dline_d [TAPS_MAX];
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] z_ext;

  // New sample enters slot 0 on accept; older samples move up and the oldest falls off.
  always_comb begin
    for (int i = 0; i < TAPS_MAX; i++) begin
      dline_d[i] = dline_q[i];
    end
    if (shift_i) begin
      dline_d[0] = sample_i;
      for (int i = 1; i < TAPS_MAX; i++) begin
        dline_d[i] = (i < TAPS) ? dline_q[i-1] : '0;
      end
    end
  end

  // Products are zero-extended only when both operands were declared unsigned.
  always_comb begin
    z_ext = {{(ACC_W-Z_W){z_i[Z_W-1] & ~zext_i}}, z_i};
    acc_d = acc_q;
    if (shift_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_q + z_ext;
    end
  end

  // Delay line and accumulator registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < TAPS_MAX; i++) begin
        dline_q[i] <= '0;
      end
      acc_q <= '0;
    end else begin
      for (int i = 0; i < TAPS_MAX; i++) begin
        dline_q[i] <= dline_d[i];
      end
      acc_q <= acc_d;
    end
  end

  assign tap_o = tap_en_i ? dline_q[tap_sel_i] : '0;
  assign acc_o = acc_q;

endmodule

// File: rtl/dsp19x2_fir_sequencer.sv
// rtl/dsp19x2_fir_sequencer.sv - dual-lane FIR tap sequencer driving an external DSP19X2
module dsp19x2_fir_sequencer
  import dsp19x2_fir_pkg::*;
#(
  parameter int TAPS        = 4,
  parameter int DSP_LATENCY = 1,
  parameter int ACC_W       = 24
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [S_W-1:0]   s_b1,
  input  logic [S_W-1:0]   s_b2,
  input  logic             cfg_unsigned_a,
  input  logic             cfg_unsigned_b,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ACC_W-1:0] m_y1,
  output logic [ACC_W-1:0] m_y2,
  output logic [S_W-1:0]   dsp_b1,
  output logic [S_W-1:0]   dsp_b2,
  output logic [2:0]       dsp_feedback,
  output logic             dsp_unsigned_a,
  output logic             dsp_unsigned_b,
  input  logic [Z_W-1:0]   dsp_z1,
  input  logic [Z_W-1:0]   dsp_z2
);

  localparam logic [1:0] K_LAST = 2'(TAPS - 1);

  state_e                 state_q, state_d;
  logic [1:0]             k_q, k_d;
  logic [DSP_LATENCY-1:0] pipe_q, pipe_d, pipe_shift;
  logic                   ua_q, ub_q;
  logic                   s_ready_q;
  logic                   accept;
  logic                   mac_active;

  assign accept     = s_valid & s_ready_q;
  assign mac_active = (state_q == MAC);

  // The tag pipe mirrors the DSP latency; an empty shifted pipe means the last product lands now.
  always_comb begin
    pipe_shift = pipe_q << 1;
    pipe_d     = pipe_shift | (DSP_LATENCY)'(mac_active);
  end

  // Sequencing: one tap per MAC cycle, DRAIN until products are in, OUT until handed off.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = MAC;
          k_d     = '0;
        end
      end
      MAC: begin
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      DRAIN: begin
        if (pipe_shift == '0) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (m_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; s_ready is registered so it reads 0 throughout reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      k_q       <= '0;
      pipe_q    <= '0;
      ua_q      <= 1'b0;
      ub_q      <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      pipe_q    <= pipe_d;
      s_ready_q <= (state_d == IDLE);
      if (accept) begin
        ua_q <= cfg_unsigned_a;
        ub_q <= cfg_unsigned_b;
      end
    end
  end

  dsp19x2_fir_lane #(
    .TAPS  (TAPS),
    .ACC_W (ACC_W)
  ) u_lane1 (
    .CLK       (CLK),
    .RESET     (RESET),
    .shift_i   (accept),
    .sample_i  (s_b1),
    .tap_sel_i (k_q),
    .tap_en_i  (mac_active),
    .acc_en_i  (pipe_q[DSP_LATENCY-1]),
    .zext_i    (ua_q & ub_q),
    .z_i       (dsp_z1),
    .tap_o     (dsp_b1),
    .acc_o     (m_y1)
  );

  dsp19x2_fir_lane #(
    .TAPS  (TAPS),
    .ACC_W (ACC_W)
  ) u_lane2 (
    .CLK       (CLK),
    .RESET     (RESET),
    .shift_i   (accept),
    .sample_i  (s_b2),
    .tap_sel_i (k_q),
    .tap_en_i  (mac_active),
    .acc_en_i  (pipe_q[DSP_LATENCY-1]),
    .zext_i    (ua_q & ub_q),
    .z_i       (dsp_z2),
    .tap_o     (dsp_b2),
    .acc_o     (m_y2)
  );

  assign s_ready        = s_ready_q;
  assign m_valid        = (state_q == OUT);
  assign dsp_feedback   = mac_active ? FB_COEFF[k_q] : FB_IDLE;
  assign dsp_unsigned_a = ua_q;
  assign dsp_unsigned_b = ub_q;

endmodule

// File: tb/tb_dsp19x2_fir_sequencer.sv
// tb/tb_dsp19x2_fir_sequencer.sv - directed bench with a behavioural DSP19X2 multiply model
module tb_dsp19x2_fir_sequencer;

  localparam int TAPS  = 4;
  localparam int LAT   = 1;
  localparam int ACC_W = 24;

  logic             CLK = 1'b0;
  logic             RESET = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [8:0]       s_b1 = '0;
  logic [8:0]       s_b2 = '0;
  logic             cfg_unsigned_a = 1'b0;
  logic             cfg_unsigned_b = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [ACC_W-1:0] m_y1, m_y2;
  logic [8:0]       dsp_b1, dsp_b2;
  logic [2:0]       dsp_feedback;
  logic             dsp_unsigned_a, dsp_unsigned_b;
  logic [18:0]      dsp_z1, dsp_z2;

  int checks = 0;
  int errors = 0;

  dsp19x2_fir_sequencer #(
    .TAPS        (TAPS),
    .DSP_LATENCY (LAT),
    .ACC_W       (ACC_W)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_b1           (s_b1),
    .s_b2           (s_b2),
    .cfg_unsigned_a (cfg_unsigned_a),
    .cfg_unsigned_b (cfg_unsigned_b),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_y1           (m_y1),
    .m_y2           (m_y2),
    .dsp_b1         (dsp_b1),
    .dsp_b2         (dsp_b2),
    .dsp_feedback   (dsp_feedback),
    .dsp_unsigned_a (dsp_unsigned_a),
    .dsp_unsigned_b (dsp_unsigned_b),
    .dsp_z1         (dsp_z1),
    .dsp_z2         (dsp_z2)
  );

  always #5 CLK = ~CLK;

  // DSP19X2 MULTIPLY with registered inputs: Z is the product of last cycle's operands.
  logic [9:0] c1 [4];
  logic [9:0] c2 [4];
  logic [8:0] r_b1 = '0, r_b2 = '0;
  logic [2:0] r_fb = '0;
  logic       r_ua = 1'b0, r_ub = 1'b0;

  always @(posedge CLK) begin
    r_b1 <= dsp_b1;
    r_b2 <= dsp_b2;
    r_fb <= dsp_feedback;
    r_ua <= dsp_unsigned_a;
    r_ub <= dsp_unsigned_b;
  end

  function automatic logic [18:0] mul19(input logic [9:0] a, input logic [8:0] b,
                                        input logic ua, input logic ub);
    logic signed [10:0] ax;
    logic signed [9:0]  bx;
    logic signed [20:0] p;
    ax = ua ? $signed({1'b0, a}) : $signed({a[9], a});
    bx = ub ? $signed({1'b0, b}) : $signed({b[8], b});
    p  = ax * bx;
    return p[18:0];
  endfunction

  always_comb begin
    dsp_z1 = '0;
    dsp_z2 = '0;
    if (r_fb[2]) begin
      dsp_z1 = mul19(c1[r_fb[1:0]], r_b1, r_ua, r_ub);
      dsp_z2 = mul19(c2[r_fb[1:0]], r_b2, r_ua, r_ub);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_default_coeffs();
    c1[0] = 10'd3;  c1[1] = 10'd5;  c1[2] = 10'd7;  c1[3] = 10'd9;
    c2[0] = -10'sd1; c2[1] = 10'd2; c2[2] = -10'sd3; c2[3] = 10'd4;
  endtask

  task automatic send(input logic [8:0] b1, input logic [8:0] b2, input logic ua, input logic ub);
    int n;
    @(negedge CLK);
    s_b1 = b1;
    s_b2 = b2;
    cfg_unsigned_a = ua;
    cfg_unsigned_b = ub;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) check("accept_timeout", n, 0);
    @(posedge CLK);
    #1 s_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input int e1, input int e2);
    int n;
    m_ready = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!m_valid && n < 100);
    check({tag, "_latency"}, n, 1 + TAPS + LAT);
    check({tag, "_y1"}, int'($signed(m_y1)), e1);
    check({tag, "_y2"}, int'($signed(m_y2)), e2);
    @(posedge CLK);
    @(negedge CLK);
    check({tag, "_mvalid_drop"}, int'(m_valid), 0);
    check({tag, "_sready_back"}, int'(s_ready), 1);
  endtask

  task automatic pair(input string tag, input logic [8:0] b1, input logic [8:0] b2,
                      input logic ua, input logic ub, input int e1, input int e2);
    send(b1, b2, ua, ub);
    recv(tag, e1, e2);
  endtask

  task automatic impulse_run(input string tag);
    pair({tag, "_t0"}, 9'd1, 9'd1, 1'b0, 1'b0, 3, -1);
    pair({tag, "_t1"}, 9'd0, 9'd0, 1'b0, 1'b0, 5, 2);
    pair({tag, "_t2"}, 9'd0, 9'd0, 1'b0, 1'b0, 7, -3);
    pair({tag, "_t3"}, 9'd0, 9'd0, 1'b0, 1'b0, 9, 4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    set_default_coeffs();

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_sready", int'(s_ready), 0);
    check("rst_mvalid", int'(m_valid), 0);
    check("rst_y1", int'(m_y1), 0);
    check("rst_fb", int'(dsp_feedback), 0);
    check("rst_b1", int'(dsp_b1), 0);
    check("rst_ua", int'(dsp_unsigned_a), 0);
    RESET = 1'b1;
    @(negedge CLK);
    check("post_rst_sready", int'(s_ready), 1);

    // Impulse response reproduces the coefficient sets
    impulse_run("imp");

    // Signed extreme: window fills with -256; coefficient sums 3, 8, 15, 24
    pair("neg0", 9'h100, 9'd0, 1'b0, 1'b0, -768, 0);
    pair("neg1", 9'h100, 9'd0, 1'b0, 1'b0, -2048, 0);
    pair("neg2", 9'h100, 9'd0, 1'b0, 1'b0, -3840, 0);
    pair("neg3", 9'h100, 9'd0, 1'b0, 1'b0, -6144, 0);

    // Backpressure: window 0,-256,-256,-256 -> -256*(5+7+9)
    send(9'd0, 9'd0, 1'b0, 1'b0);
    m_ready = 1'b0;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!m_valid && n < 100);
    check("bp_latency", n, 1 + TAPS + LAT);
    s_b1 = 9'd100;
    s_b2 = 9'd100;
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("bp_hold_y1", int'($signed(m_y1)), -5376);
      check("bp_hold_y2", int'($signed(m_y2)), 0);
      check("bp_hold_mvalid", int'(m_valid), 1);
      check("bp_hold_sready", int'(s_ready), 0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("bp_mvalid_drop", int'(m_valid), 0);
    @(negedge CLK);
    check("bp_no_duplicate", int'(m_valid), 0);

    // Unsigned: coefficients 1023, samples 511 on top of 0,256,256,256 (0x100 read unsigned)
    c1[0] = 10'h3FF; c1[1] = 10'h3FF; c1[2] = 10'h3FF; c1[3] = 10'h3FF;
    pair("uns0", 9'd511, 9'd0, 1'b1, 1'b1, 1046529, 0);
    pair("uns1", 9'd511, 9'd0, 1'b1, 1'b1, 1307394, 0);
    pair("uns2", 9'd511, 9'd0, 1'b1, 1'b1, 1568259, 0);
    pair("uns3", 9'd511, 9'd0, 1'b1, 1'b1, 2091012, 0);
    check("uns_cfg_a", int'(dsp_unsigned_a), 1);
    check("uns_cfg_b", int'(dsp_unsigned_b), 1);
    set_default_coeffs();

    // Reset during MAC tap 2 discards the in-flight result and the delay lines
    send(9'd1, 9'd1, 1'b0, 1'b0);
    @(negedge CLK);
    check("mac_k0_fb", int'(dsp_feedback), 4);
    check("mac_k0_b1", int'(dsp_b1), 1);
    check("mac_k0_b2", int'(dsp_b2), 1);
    @(negedge CLK);
    @(negedge CLK);
    check("mac_k2_fb", int'(dsp_feedback), 6);
    RESET = 1'b0;
    #1;
    check("midrst_mvalid", int'(m_valid), 0);
    check("midrst_sready", int'(s_ready), 0);
    check("midrst_fb", int'(dsp_feedback), 0);
    check("midrst_b1", int'(dsp_b1), 0);
    check("midrst_y1", int'(m_y1), 0);
    @(negedge CLK);
    RESET = 1'b1;
    impulse_run("imp_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
